// File: rtl/cache_write_buffer.sv
// Posted-write buffer between the D-cache memory port and main memory.
// Writes are queued and acked at once; reads wait until the queue drains.
module cache_write_buffer #(
  parameter int addr_width = 32,
  parameter int data_width = 32,
  parameter int depth      = 4
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic                         up_req,
  input  logic [addr_width-1:0]        up_addr,
  input  logic                         up_we,
  input  logic [3:0]                   up_be,
  input  logic [data_width-1:0]        up_wdata,
  output logic                         up_gnt,
  output logic                         up_rvalid,
  output logic [data_width-1:0]        up_rdata,
  output logic                         mem_req,
  output logic [addr_width-1:0]        mem_addr,
  output logic                         mem_we,
  output logic [3:0]                   mem_be,
  output logic [data_width-1:0]        mem_wdata,
  input  logic                         mem_gnt,
  input  logic                         mem_rvalid,
  input  logic [data_width-1:0]        mem_rdata,
  output logic [$clog2(depth+1)-1:0]   buf_count
);

  localparam int pw = $clog2(depth);
  localparam int cw = $clog2(depth+1);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP
  } state_t;

  state_t state, state_nxt;

  logic [addr_width-1:0] fifo_addr [depth];
  logic [3:0]            fifo_be   [depth];
  logic [data_width-1:0] fifo_data [depth];

  logic [pw-1:0] wr_ptr, rd_ptr, head;
  logic [cw-1:0] count;
  logic          full, empty, rd_busy;
  logic          push, pop, rd_gnt;
  logic          req_nxt, load_wr, load_rd, rsp_rd;

  assign full      = count == cw'(depth);
  assign empty     = count == '0;
  assign rd_busy   = (state == RD_REQ) || (state == RD_RESP);
  assign push      = up_req & up_we & ~full & ~rd_busy;
  assign rd_gnt    = up_req & ~up_we & empty & (state == IDLE);
  assign up_gnt    = push | rd_gnt;
  assign pop       = (state == WR_RESP) & mem_rvalid;
  assign buf_count = count;

  // The head moves on the same edge as a pop, so look one slot ahead.
  assign head = pop ? rd_ptr + pw'(1) : rd_ptr;

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wr_ptr] <= up_addr;
      fifo_be[wr_ptr]   <= up_be;
      fifo_data[wr_ptr] <= up_wdata;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + pw'(1);
      if (pop)  rd_ptr <= rd_ptr + pw'(1);
      if (push && !pop)      count <= count + cw'(1);
      else if (pop && !push) count <= count - cw'(1);
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!empty)      state_nxt = WR_REQ;
        else if (rd_gnt) state_nxt = RD_REQ;
      end
      WR_REQ:  if (mem_gnt) state_nxt = WR_RESP;
      WR_RESP: begin
        if (mem_rvalid)
          state_nxt = (count > cw'(1)) ? WR_REQ : IDLE;
      end
      RD_REQ:  if (mem_gnt) state_nxt = RD_RESP;
      RD_RESP: if (mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_nxt = (state_nxt == WR_REQ) || (state_nxt == RD_REQ);
    load_wr = (state_nxt == WR_REQ) && (state != WR_REQ);
    load_rd = (state_nxt == RD_REQ) && (state != RD_REQ);
    rsp_rd  = (state == RD_RESP) && mem_rvalid;
  end

  // Memory-side fields load only on entry to a request state, so they
  // hold steady across any grant stall.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_wdata <= '0;
      up_rvalid <= 1'b0;
      up_rdata  <= '0;
    end else begin
      mem_req <= req_nxt;
      if (load_wr) begin
        mem_addr  <= fifo_addr[head];
        mem_be    <= fifo_be[head];
        mem_wdata <= fifo_data[head];
        mem_we    <= 1'b1;
      end else if (load_rd) begin
        mem_addr <= up_addr;
        mem_be   <= up_be;
        mem_we   <= 1'b0;
      end
      up_rvalid <= push | rsp_rd;
      if (rsp_rd) up_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_cache_write_buffer.sv
// Directed bench for cache_write_buffer with a small scripted memory.
// Each scenario task drives stimulus and checks its own results.
module tb_cache_write_buffer;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        up_req, up_we;
  logic [31:0] up_addr, up_wdata;
  logic [3:0]  up_be;
  logic        up_gnt, up_rvalid;
  logic [31:0] up_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic [2:0]  buf_count;

  int n_checks = 0;
  int n_fail = 0;

  logic        outstanding = 1'b0;
  logic        out_we = 1'b0;
  logic [31:0] out_addr = '0;
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  logic        log_we [$];
  int          n_wresp = 0;
  int          n_rresp = 0;

  cache_write_buffer dut (
    .clock(clock), .rst(rst),
    .up_req(up_req), .up_addr(up_addr), .up_we(up_we),
    .up_be(up_be), .up_wdata(up_wdata),
    .up_gnt(up_gnt), .up_rvalid(up_rvalid), .up_rdata(up_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .buf_count(buf_count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_up();
    up_req = 0; up_we = 0; up_addr = 0; up_be = 0; up_wdata = 0;
  endtask

  // One cycle of a memory that grants at once and answers next cycle.
  task automatic mem_cycle();
    mem_rvalid = outstanding;
    mem_gnt = mem_req && !outstanding;
    mem_rdata = 32'h0;
    if (outstanding && !out_we && mem_model.exists(out_addr))
      mem_rdata = mem_model[out_addr];
    #1;
    if (mem_rvalid) begin
      if (out_we) n_wresp++;
      else n_rresp++;
      outstanding = 0;
    end
    if (mem_req && mem_gnt) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
      log_we.push_back(mem_we);
      if (mem_we) mem_model[mem_addr] = mem_wdata;
      outstanding = 1;
      out_we = mem_we;
      out_addr = mem_addr;
    end
  endtask

  task automatic test_reset();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      up_req = 0;
      up_we = 1'($urandom_range(0, 1));
      up_addr = $urandom;
      up_be = 4'($urandom_range(0, 15));
      up_wdata = $urandom;
      mem_gnt = 1'($urandom_range(0, 1));
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      step();
      n_checks++;
      if ({up_gnt, up_rvalid, mem_req, mem_we} !== 4'b0) begin
        n_fail++;
        $display("FAIL reset_ctl got %b want 0000",
                 {up_gnt, up_rvalid, mem_req, mem_we});
      end
      n_checks++;
      if ({up_rdata, mem_addr, mem_wdata} !== 96'h0) begin
        n_fail++;
        $display("FAIL reset_data got %h %h %h want 0",
                 up_rdata, mem_addr, mem_wdata);
      end
      n_checks++;
      if ({mem_be, buf_count} !== 7'h0) begin
        n_fail++;
        $display("FAIL reset_be_count got be=%h count=%0d want 0",
                 mem_be, buf_count);
      end
    end
    idle_up();
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    step();
    rst = 1;
    step();
  endtask

  task automatic test_single_write();
    logic found;
    logic done;
    int   base;
    base = n_wresp;
    up_req = 1; up_we = 1; up_addr = 32'h100;
    up_wdata = 32'hDEADBEEF; up_be = 4'hF;
    mem_gnt = 0; mem_rvalid = 0;
    #1;
    n_checks++;
    if (up_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL single_gnt got %b want 1", up_gnt);
    end
    step();
    idle_up();
    #1;
    n_checks++;
    if (up_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ack got %b want 1", up_rvalid);
    end
    found = mem_req;
    if (!found) begin
      step();
      #1;
      found = mem_req;
    end
    n_checks++;
    if (found !== 1'b1) begin
      n_fail++;
      $display("FAIL single_memreq got %b want 1", found);
    end
    n_checks++;
    if ({mem_we, mem_be, mem_addr, mem_wdata} !==
        {1'b1, 4'hF, 32'h100, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL single_mem got we=%b be=%h a=%h d=%h want 1 f 100 deadbeef",
               mem_we, mem_be, mem_addr, mem_wdata);
    end
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      mem_cycle();
      if (buf_count == 0 && !mem_req && !outstanding && n_wresp > base)
        done = 1;
      else
        step();
    end
    mem_gnt = 0; mem_rvalid = 0;
    n_checks++;
    if (done !== 1'b1 || buf_count !== 3'd0) begin
      n_fail++;
      $display("FAIL single_drain got done=%b count=%0d want 1 0",
               done, buf_count);
    end
    step();
  endtask

  task automatic test_fill();
    logic granted;
    logic done;
    int   pops_at_gnt;
    int   base;
    log_addr.delete(); log_data.delete(); log_we.delete();
    base = n_wresp;
    mem_gnt = 0; mem_rvalid = 0;
    for (int i = 0; i < 4; i++) begin
      up_req = 1; up_we = 1; up_be = 4'hF;
      up_addr = 32'h10 + 32'(4 * i);
      up_wdata = 32'hA0 + 32'(i);
      #1;
      n_checks++;
      if (up_gnt !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_gnt%0d got %b want 1", i, up_gnt);
      end
      step();
    end
    up_addr = 32'h20; up_wdata = 32'hA4;
    #1;
    n_checks++;
    if (up_gnt !== 1'b0 || buf_count !== 3'd4) begin
      n_fail++;
      $display("FAIL fill_full got gnt=%b count=%0d want 0 4",
               up_gnt, buf_count);
    end
    step();
    granted = 0; done = 0; pops_at_gnt = -1;
    for (int i = 0; i < 40 && !done; i++) begin
      mem_cycle();
      if (up_req && up_gnt) begin
        granted = 1;
        pops_at_gnt = n_wresp - base;
      end
      if (granted && !up_req && buf_count == 0 && !mem_req && !outstanding)
        done = 1;
      else begin
        step();
        if (granted) idle_up();
      end
    end
    mem_gnt = 0; mem_rvalid = 0;
    n_checks++;
    if (granted !== 1'b1 || pops_at_gnt != 1) begin
      n_fail++;
      $display("FAIL fill_fifth got granted=%b pops=%0d want 1 1",
               granted, pops_at_gnt);
    end
    n_checks++;
    if (log_addr.size() != 5) begin
      n_fail++;
      $display("FAIL fill_count got %0d want 5", log_addr.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (log_addr[i] !== 32'h10 + 32'(4 * i) ||
            log_data[i] !== 32'hA0 + 32'(i) || log_we[i] !== 1'b1) begin
          n_fail++;
          $display("FAIL fill_order%0d got a=%h d=%h we=%b want %h %h 1",
                   i, log_addr[i], log_data[i], log_we[i],
                   32'h10 + 32'(4 * i), 32'hA0 + 32'(i));
        end
      end
    end
    step();
  endtask

  task automatic test_read_after_write();
    logic rd_granted;
    logic early;
    logic rsp_prev;
    logic done;
    int   wbase;
    int   rbase;
    int   rprev;
    log_addr.delete(); log_data.delete(); log_we.delete();
    wbase = n_wresp; rbase = n_rresp;
    up_req = 1; up_we = 1; up_addr = 32'h200;
    up_wdata = 32'h55; up_be = 4'hF;
    mem_cycle();
    n_checks++;
    if (up_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_wgnt got %b want 1", up_gnt);
    end
    step();
    up_we = 0; up_wdata = 0;
    rd_granted = 0; early = 0; rsp_prev = 0; done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      rprev = n_rresp;
      mem_cycle();
      if (rsp_prev) begin
        done = 1;
        n_checks++;
        if (up_rvalid !== 1'b1 || up_rdata !== 32'h55) begin
          n_fail++;
          $display("FAIL raw_rdata got v=%b d=%h want 1 55",
                   up_rvalid, up_rdata);
        end
      end
      rsp_prev = (n_rresp != rprev);
      if (up_req && up_gnt) begin
        rd_granted = 1;
        if (n_wresp == wbase) early = 1;
      end
      if (!done) begin
        step();
        if (rd_granted) idle_up();
      end
    end
    mem_gnt = 0; mem_rvalid = 0;
    n_checks++;
    if (rd_granted !== 1'b1 || early !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_order got gnt=%b early=%b done=%b want 1 0 1",
               rd_granted, early, done);
    end
    n_checks++;
    if (log_addr.size() != 2 || log_addr[1] !== 32'h200 ||
        log_we[1] !== 1'b0 || n_rresp != rbase + 1) begin
      n_fail++;
      $display("FAIL raw_memread got n=%0d want 2 entries ending read 200",
               log_addr.size());
    end
    step();
  endtask

  task automatic test_stall();
    up_req = 1; up_we = 1; up_addr = 32'h300;
    up_wdata = 32'h12345678; up_be = 4'h3;
    mem_gnt = 0; mem_rvalid = 0;
    step();
    idle_up();
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_gnt = 1;
      #1;
      n_checks++;
      if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !==
          {1'b1, 1'b1, 4'h3, 32'h300, 32'h12345678}) begin
        n_fail++;
        $display("FAIL stall_hold%0d got r=%b be=%h a=%h d=%h want 1 3 300 12345678",
                 i, mem_req, mem_be, mem_addr, mem_wdata);
      end
      step();
    end
    mem_gnt = 0; mem_rvalid = 1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_drop got %b want 0", mem_req);
    end
    step();
    mem_rvalid = 0;
    #1;
    n_checks++;
    if (buf_count !== 3'd0) begin
      n_fail++;
      $display("FAIL stall_count got %0d want 0", buf_count);
    end
    step();
  endtask

  task automatic test_reset_mid();
    up_req = 1; up_we = 0; up_addr = 32'h200; up_be = 4'hF;
    mem_gnt = 0; mem_rvalid = 0;
    #1;
    n_checks++;
    if (up_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_gnt got %b want 1", up_gnt);
    end
    step();
    idle_up();
    mem_gnt = 1;
    #1;
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_req got r=%b we=%b want 1 0", mem_req, mem_we);
    end
    step();
    mem_gnt = 0;
    rst = 0;
    #1;
    n_checks++;
    if (up_rvalid !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async got v=%b r=%b want 0 0",
               up_rvalid, mem_req);
    end
    step();
    rst = 1;
    step();
    mem_rvalid = 1; mem_rdata = 32'hBAD;
    step();
    mem_rvalid = 0; mem_rdata = 0;
    #1;
    n_checks++;
    if (up_rvalid !== 1'b0 || buf_count !== 3'd0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_after got v=%b count=%0d r=%b want 0 0 0",
               up_rvalid, buf_count, mem_req);
    end
    up_req = 1; up_we = 0; up_addr = 32'h40;
    #1;
    n_checks++;
    if (up_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_idle got %b want 1", up_gnt);
    end
    idle_up();
    step();
  endtask

  initial begin
    idle_up();
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    test_reset();
    test_single_write();
    test_fill();
    test_read_after_write();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
